irrigation_sequencer: RTL and testbench
=======================================

Name: irrigation_sequencer

Overview:
Multi-zone successor to the single-box irrigation state machine. It controls one water tank: fill, serve N_ZONES irrigation zones in round-robin order, then drain/clean. Each zone selects sprinkler mode (continuous valve) or drip mode (pulsed valve).
- New relative to the single-box controller: bounded per-zone watering time, fill timeout, tank-sensor plausibility check, and a sticky error state with explicit clear.
- Sits between the tank/zone sensors and the pump/valve drivers.

Parameters:
N_ZONES, 4, number of irrigation zones (2..16)
TIMER_W, 16, width of all internal cycle counters
FILL_TIMEOUT, 1000, max cycles in FILLING before a timeout error
WATER_MAX, 500, max cycles one zone may water per grant
CLEAN_CYCLES, 50, max cycles in CLEANING when clean_done never arrives
DRIP_ON, 4, drip-mode valve-open cycles per pulse period
DRIP_OFF, 12, drip-mode valve-closed cycles per pulse period

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
level_h  in  1  tank high-level sensor
level_l  in  1  tank low-level sensor (1 = water above low mark)
zone_req  in  N_ZONES  per-zone watering request, level-sensitive
zone_mode  in  N_ZONES  per-zone mode: 1 = sprinkler, 0 = drip
clean_done  in  1  cleaning-complete sensor
fault_in  in  1  external fault
err_clr  in  1  error acknowledge
fill_valve  out  1  tank inlet valve
pump  out  1  irrigation pump
zone_valve  out  N_ZONES  one-hot zone valves
drain_valve  out  1  cleaning drain valve
led_busy  out  1  high in WATER
error  out  1  high in ERROR
err_code  out  2  0 none, 1 external fault, 2 fill timeout, 3 sensor implausible
active_zone  out  clog2(N_ZONES)  zone being served
state_o  out  3  current state code

Behaviour:
- Interface fixed: one clock, clock; reset is synchronous and active-high, named reset.
- Moore outputs decoded from registered state and the drip phase register. An input sampled at edge k changes outputs after edge k.
- Reset:
  - state = FILLING; all counters = 0; rr pointer = N_ZONES-1, so zone 0 has first priority.
  - err_code = 0; outputs take their FILLING values.
  - Reset beats every other event and may occur in any state.
- States and codes:
  - FILLING=0: fill_valve = 1.
    - level_h → IDLE.
    - Counter reaches FILL_TIMEOUT-1 → ERROR, err_code = 2.
  - IDLE=1: all outputs 0.
    - If any zone_req bit is set and level_l = 1 → WATER. Grant the first requester after the rr pointer (wrap-around). Latch active_zone and its zone_mode; update the pointer.
    - If level_l = 0 → CLEANING.
  - WATER=2: pump = 1, led_busy = 1, zone_valve[active_zone] = 1.
    - Sprinkler mode: valve held open.
    - Drip mode: valve open for DRIP_ON cycles, then closed for DRIP_OFF cycles, repeating. The phase counter restarts on WATER entry.
    - level_l falls → CLEANING.
    - Otherwise, zone_req[active_zone] falls or the counter reaches WATER_MAX-1 → IDLE.
  - CLEANING=3: drain_valve = 1.
    - clean_done, or the counter reaches CLEAN_CYCLES-1 → FILLING.
  - ERROR=4: all actuators 0, error = 1.
    - Leave only when err_clr = 1 and fault_in = 0 → FILLING; err_code clears at that edge.
- Priority at any edge (highest first): reset, fault_in, sensor implausible (level_h=1 and level_l=0), state-local conditions.
  - fault_in → ERROR with err_code = 1.
  - Sensor implausible → ERROR with err_code = 3.
- In ERROR, err_code keeps its first cause. A later different fault does not overwrite it.
- zone_mode is latched at grant; changes during WATER are ignored.
- All counters clear on every state change and saturate; they never wrap.
- Elaboration checks on parameters: each timeout < 2**TIMER_W, DRIP_ON ≥ 1, DRIP_OFF ≥ 1.
- Unused state codes 5..7 go to FILLING on the next edge.

Decomposition:
- Shared package irrigation_pkg:
  - state enum/codes
  - err_code constants
  - sensor-implausible helper function
- Sub-module rr_arbiter (parameter N): inputs req, pointer, enable; outputs grant index and valid.
- Timers stay inline.

Test Plan:
- Reset, then level_h after 10 cycles → fill_valve high for 10 cycles, then state_o = 1, all outputs 0.
- IDLE, level_l = 1, zone_req = 4'b1010, zone_mode = 4'b0010 → zone 1 sprinkler, valve steady.
  - Drop req[1] → zone 3 drip: zone_valve[3] follows a 4-on/12-off pattern from entry.
- zone_req[0] held, WATER_MAX = 500 → after 500 cycles, IDLE for one cycle, then re-grant.
  - With req = 4'b0011, the grant alternates 0, 1, 0.
- level_l falls mid-WATER while zone_req also drops → CLEANING (level_l wins); clean_done never asserts → FILLING after 50 cycles.
- FILLING with level_h never asserted → ERROR at cycle 1000, err_code = 2.
  - err_clr while fault_in = 1 → stays in ERROR.
  - err_clr with fault_in = 0 → FILLING, err_code = 0.
- level_h = 1, level_l = 0 in IDLE → ERROR with err_code = 3.
  - fault_in in the same cycle → err_code = 1.
  - Reset mid-WATER → FILLING, pump = 0.

Source files
------------

// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared state codes, error codes and sensor helper for irrigation_sequencer
package irrigation_pkg;
  typedef enum logic [2:0] {
    FILLING  = 3'd0,
    IDLE     = 3'd1,
    WATER    = 3'd2,
    CLEANING = 3'd3,
    ERROR    = 3'd4
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FAULT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SENSOR  = 2'd3;
  function automatic logic implausible(input logic high, input logic low);
    return high & ~low;
  endfunction
endpackage

// File: rtl/irrigation_sequencer_rr_arbiter.sv
// rr_arbiter: grants the first requester strictly after pointer, wrapping around
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  input  logic         enable,
  output logic [W-1:0] grant,
  output logic         valid
);
  always_comb begin
    grant = '0;
    valid = 1'b0;
    // scan farthest to nearest so the nearest requester is written last
    for (int i = N; i >= 1; i--) begin
      if (enable && req[(int'(pointer) + i) % N]) begin
        grant = W'((int'(pointer) + i) % N);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: tank fill, round-robin zone watering (sprinkler/drip), drain/clean, sticky error
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int N_ZONES      = 4,
  parameter int TIMER_W      = 16,
  parameter int FILL_TIMEOUT = 1000,
  parameter int WATER_MAX    = 500,
  parameter int CLEAN_CYCLES = 50,
  parameter int DRIP_ON      = 4,
  parameter int DRIP_OFF     = 12,
  localparam int ZW          = $clog2(N_ZONES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               level_h,
  input  logic               level_l,
  input  logic [N_ZONES-1:0] zone_req,
  input  logic [N_ZONES-1:0] zone_mode,
  input  logic               clean_done,
  input  logic               fault_in,
  input  logic               err_clr,
  output logic               fill_valve,
  output logic               pump,
  output logic [N_ZONES-1:0] zone_valve,
  output logic               drain_valve,
  output logic               led_busy,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [ZW-1:0]      active_zone,
  output logic [2:0]         state_o
);
  localparam int PERIOD = DRIP_ON + DRIP_OFF;
  localparam int PW = $clog2(PERIOD);
  localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] WATER_LAST = TIMER_W'(WATER_MAX - 1);
  localparam logic [TIMER_W-1:0] CLEAN_LAST = TIMER_W'(CLEAN_CYCLES - 1);
  if (FILL_TIMEOUT < 1 || WATER_MAX < 1 || CLEAN_CYCLES < 1 ||
      longint'(FILL_TIMEOUT) >= (longint'(1) << TIMER_W) ||
      longint'(WATER_MAX) >= (longint'(1) << TIMER_W) ||
      longint'(CLEAN_CYCLES) >= (longint'(1) << TIMER_W) ||
      DRIP_ON < 1 || DRIP_OFF < 1 || N_ZONES < 2 || N_ZONES > 16) begin : g_param_check
    $error("irrigation_sequencer: illegal parameter set");
  end
  state_t state, state_nxt;
  logic [TIMER_W-1:0] cnt;
  logic [PW-1:0] phase;
  logic [ZW-1:0] ptr, zone, gnt;
  logic mode, gnt_valid;
  logic [1:0] code, code_nxt;
  rr_arbiter #(.N(N_ZONES)) u_arb (
    .req(zone_req),
    .pointer(ptr),
    .enable(level_l),
    .grant(gnt),
    .valid(gnt_valid)
  );
  always_comb begin
    state_nxt = state;
    code_nxt = code;
    if (fault_in || implausible(level_h, level_l)) begin
      state_nxt = ERROR;
      code_nxt = state == ERROR ? code : fault_in ? ERR_FAULT : ERR_SENSOR;
    end else begin
      case (state)
        FILLING: begin
          state_nxt = level_h ? IDLE : cnt == FILL_LAST ? ERROR : FILLING;
          code_nxt = (!level_h && cnt == FILL_LAST) ? ERR_TIMEOUT : code;
        end
        IDLE:     state_nxt = !level_l ? CLEANING : gnt_valid ? WATER : IDLE;
        WATER:    state_nxt = !level_l ? CLEANING : (!zone_req[zone] || cnt == WATER_LAST) ? IDLE : WATER;
        CLEANING: state_nxt = (clean_done || cnt == CLEAN_LAST) ? FILLING : CLEANING;
        ERROR: begin
          state_nxt = err_clr ? FILLING : ERROR;
          code_nxt = err_clr ? ERR_NONE : code;
        end
        default:  state_nxt = FILLING;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILLING;
      code <= ERR_NONE;
      cnt <= '0;
      phase <= '0;
      ptr <= ZW'(N_ZONES - 1);
      zone <= '0;
      mode <= 1'b0;
    end else begin
      state <= state_nxt;
      code <= code_nxt;
      cnt <= state_nxt != state ? '0 : &cnt ? cnt : cnt + 1'b1;
      phase <= (state_nxt != state || phase == PW'(PERIOD - 1)) ? '0 : phase + 1'b1;
      if (state == IDLE && state_nxt == WATER) begin
        zone <= gnt;
        mode <= zone_mode[gnt];
        ptr <= gnt;
      end
    end
  end
  assign fill_valve  = state == FILLING;
  assign pump        = state == WATER;
  assign led_busy    = state == WATER;
  assign drain_valve = state == CLEANING;
  assign error       = state == ERROR;
  assign zone_valve  = (state == WATER && (mode || phase < PW'(DRIP_ON))) ? N_ZONES'(1) << zone : '0;
  assign err_code    = code;
  assign active_zone = zone;
  assign state_o     = state;
endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb_irrigation_sequencer: directed plan checks plus randomized run against a cycle-level behavioural model
module tb_irrigation_sequencer;
  localparam int N = 4, FT = 1000, WM = 500, CC = 50, DON = 4, DOFF = 12;
  logic clock = 1'b0, reset = 1'b1, level_h = 1'b0, level_l = 1'b0;
  logic clean_done = 1'b0, fault_in = 1'b0, err_clr = 1'b0;
  logic [N-1:0] zone_req = '0, zone_mode = '0;
  logic fill_valve, pump, drain_valve, led_busy, error;
  logic [N-1:0] zone_valve;
  logic [1:0] err_code, active_zone;
  logic [2:0] state_o;
  logic [15:0] drip = 16'h000F;
  int total = 0, bad = 0;
  int m_st = 0, m_t = 0, m_ptr = N - 1, m_zone = 0, m_code = 0;
  logic m_mode = 1'b0;
  always #5 clock = ~clock;
  irrigation_sequencer #(
    .N_ZONES(N), .TIMER_W(16), .FILL_TIMEOUT(FT), .WATER_MAX(WM),
    .CLEAN_CYCLES(CC), .DRIP_ON(DON), .DRIP_OFF(DOFF)
  ) dut (
    .clock(clock), .reset(reset), .level_h(level_h), .level_l(level_l),
    .zone_req(zone_req), .zone_mode(zone_mode), .clean_done(clean_done),
    .fault_in(fault_in), .err_clr(err_clr), .fill_valve(fill_valve), .pump(pump),
    .zone_valve(zone_valve), .drain_valve(drain_valve), .led_busy(led_busy),
    .error(error), .err_code(err_code), .active_zone(active_zone), .state_o(state_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask
  // model: state number plus cycles spent in it; drip phase is derived from time in WATER
  task automatic model_step();
    int ns;
    if (reset) begin
      m_st = 0; m_t = 0; m_ptr = N - 1; m_zone = 0; m_mode = 1'b0; m_code = 0;
      return;
    end
    ns = m_st;
    if (fault_in || (level_h && !level_l)) begin
      ns = 4;
      if (m_st != 4) m_code = fault_in ? 1 : 3;
    end else if (m_st == 0) begin
      if (level_h) ns = 1;
      else if (m_t >= FT - 1) begin ns = 4; m_code = 2; end
    end else if (m_st == 1) begin
      if (!level_l) ns = 3;
      else if (zone_req != 0) begin
        for (int k = N; k >= 1; k--)
          if (zone_req[(m_ptr + k) % N]) m_zone = (m_ptr + k) % N;
        ns = 2; m_ptr = m_zone; m_mode = zone_mode[m_zone];
      end
    end else if (m_st == 2) begin
      if (!level_l) ns = 3;
      else if (!zone_req[m_zone] || m_t >= WM - 1) ns = 1;
    end else if (m_st == 3) begin
      if (clean_done || m_t >= CC - 1) ns = 0;
    end else if (err_clr) begin
      ns = 0; m_code = 0;
    end
    m_t = ns != m_st ? 0 : m_t + 1;
    m_st = ns;
  endtask
  initial forever begin
    @(posedge clock);
    model_step();
  end
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      chk("m_state", state_o, m_st);
      chk("m_fill", fill_valve, m_st == 0);
      chk("m_pump", pump, m_st == 2);
      chk("m_busy", led_busy, m_st == 2);
      chk("m_drain", drain_valve, m_st == 3);
      chk("m_error", error, m_st == 4);
      chk("m_code", err_code, m_code);
      chk("m_zone", active_zone, m_zone);
      chk("m_valve", zone_valve,
          (m_st == 2 && (m_mode || (m_t % (DON + DOFF)) < DON)) ? (1 << m_zone) : 0);
    end
  end
  initial begin
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("fill_hold", fill_valve, 1);
    end
    level_h = 1'b1; level_l = 1'b1;
    step(1);
    chk("idle_state", state_o, 1);
    chk("idle_fill", fill_valve, 0);
    chk("idle_valves", zone_valve, 0);
    level_h = 1'b0; zone_req = 4'b1010; zone_mode = 4'b0010;
    step(1);
    chk("grant1_state", state_o, 2);
    chk("grant1_zone", active_zone, 1);
    for (int i = 0; i < 20; i++) begin
      chk("sprinkler", zone_valve, 4'b0010);
      step(1);
    end
    zone_req = 4'b1000;
    step(1);
    chk("drop_idle", state_o, 1);
    step(1);
    chk("grant3_zone", active_zone, 3);
    for (int j = 0; j < 32; j++) begin
      chk("drip", zone_valve, drip[j % 16] ? 4'b1000 : 4'b0000);
      step(1);
    end
    zone_req = 4'b0001; zone_mode = 4'b0001;
    step(2);
    chk("grant0_zone", active_zone, 0);
    step(499);
    chk("wmax_last", state_o, 2);
    step(1);
    chk("wmax_idle", state_o, 1);
    step(1);
    chk("regrant", state_o, 2);
    zone_req = 4'b0011;
    step(501);
    chk("alt_zone1", active_zone, 1);
    step(501);
    chk("alt_zone0", active_zone, 0);
    step(5);
    level_l = 1'b0; zone_req = 4'b0000;
    step(1);
    chk("low_clean", state_o, 3);
    step(49);
    chk("clean_last", state_o, 3);
    step(1);
    chk("clean_fill", state_o, 0);
    step(999);
    chk("fill_last", state_o, 0);
    step(1);
    chk("timeout_state", state_o, 4);
    chk("timeout_code", err_code, 2);
    fault_in = 1'b1; err_clr = 1'b1;
    step(1);
    chk("clr_blocked", state_o, 4);
    chk("code_kept", err_code, 2);
    fault_in = 1'b0;
    step(1);
    chk("clr_state", state_o, 0);
    chk("clr_code", err_code, 0);
    err_clr = 1'b0; level_h = 1'b1; level_l = 1'b1;
    step(1);
    level_l = 1'b0;
    step(1);
    chk("sensor_code", err_code, 3);
    level_h = 1'b0; level_l = 1'b1; err_clr = 1'b1;
    step(1);
    err_clr = 1'b0; level_h = 1'b1;
    step(1);
    level_l = 1'b0; fault_in = 1'b1;
    step(1);
    chk("fault_wins", err_code, 1);
    fault_in = 1'b0; level_h = 1'b0; level_l = 1'b1; err_clr = 1'b1;
    step(1);
    err_clr = 1'b0; level_h = 1'b1;
    step(1);
    level_h = 1'b0; zone_req = 4'b0001;
    step(1);
    chk("pre_reset_pump", pump, 1);
    reset = 1'b1;
    step(1);
    chk("reset_pump", pump, 0);
    chk("reset_state", state_o, 0);
    reset = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      fault_in   = $urandom_range(0, 299) == 0;
      err_clr    = $urandom_range(0, 9) == 0;
      level_l    = $urandom_range(0, 49) != 0;
      level_h    = $urandom_range(0, 14) == 0;
      clean_done = $urandom_range(0, 29) == 0;
      reset      = $urandom_range(0, 1999) == 0;
      if ($urandom_range(0, 39) == 0) zone_req = N'($urandom);
      if ($urandom_range(0, 9) == 0) zone_mode = N'($urandom);
      step(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
